// File: rtl/xgcd_operand_loader_if.sv
// xgcd_operand_loader_if: operand word stream from the loader to the XGCD datapath.
// Valid/ready handshake plus the sel/idx/last tag that travels with each word.
interface xgcd_operand_loader_if #(
    parameter int DATA_W = 64
);
    logic              OP_VALID;
    logic              OP_READY;
    logic [DATA_W-1:0] OP_DATA;
    logic              OP_SEL;
    logic [4:0]        OP_IDX;
    logic              OP_LAST;

    modport master (
        output OP_VALID,
        output OP_DATA,
        output OP_SEL,
        output OP_IDX,
        output OP_LAST,
        input  OP_READY
    );

    modport slave (
        input  OP_VALID,
        input  OP_DATA,
        input  OP_SEL,
        input  OP_IDX,
        input  OP_LAST,
        output OP_READY
    );
endinterface

// File: rtl/xgcd_operand_loader.sv
// xgcd_operand_loader: reads N words from bank A then N from bank B and
// streams them out through a small credit-controlled FIFO.
module xgcd_operand_loader #(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 3
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic                START,
    input  logic [5:0]          NWORDS,
    output logic                BUSY,
    output logic                DONE,
    output logic                MEM_CEn,
    output logic [31:0]         MEM_ADDR,
    input  logic [DATA_W-1:0]   MEM_RDATA,
    xgcd_operand_loader_if.master op
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [5:0]        r_n;
    logic [5:0]        r_issue;

    logic              r_inflight;
    logic              r_tag_sel;
    logic [4:0]        r_tag_idx;
    logic              r_tag_last;

    logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
    logic              r_mem_sel  [FIFO_DEPTH];
    logic [4:0]        r_mem_idx  [FIFO_DEPTH];
    logic              r_mem_last [FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic [5:0]        w_n_start;
    logic              w_bank;
    logic [4:0]        w_idx;
    logic              w_last_issue;
    logic [CW:0]       w_occ;
    logic              w_credit;
    logic              w_issue;
    logic              w_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_head_last;

    // Out-of-range counts saturate at 32 so the 6-bit issue counter never wraps.
    assign w_n_start = (NWORDS == 6'd0 || NWORDS > 6'd32) ? 6'd32 : NWORDS;

    assign w_bank = (r_issue >= r_n);
    // Mod-32 subtraction is exact here because the index is always below 32.
    assign w_idx = r_issue[4:0] - (w_bank ? r_n[4:0] : 5'd0);
    assign w_last_issue = w_bank && (w_idx == 5'(r_n[4:0] - 5'd1));

    // Credit excludes a same-cycle pop, so FIFO + in-flight never exceeds depth.
    assign w_occ = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_credit = (w_occ < (CW + 1)'(FIFO_DEPTH));
    assign w_issue = (r_state == S_FETCH) && w_credit;

    assign w_valid = (r_count != '0);
    assign w_push = r_inflight;
    assign w_pop = w_valid && op.OP_READY;
    assign w_head_last = r_mem_last[r_rd_ptr];

    assign BUSY = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign DONE = (r_state == S_DONE);
    assign MEM_CEn = ~w_issue;
    assign MEM_ADDR = w_issue ? {23'd0, w_bank, w_idx, 3'd0} : 32'd0;

    // Head fields are gated by valid so an empty FIFO presents all zeros.
    assign op.OP_VALID = w_valid;
    assign op.OP_DATA = w_valid ? r_mem_data[r_rd_ptr] : '0;
    assign op.OP_SEL = w_valid ? r_mem_sel[r_rd_ptr] : 1'b0;
    assign op.OP_IDX = w_valid ? r_mem_idx[r_rd_ptr] : 5'd0;
    assign op.OP_LAST = w_valid ? w_head_last : 1'b0;

    // Control FSM: latch N on start, walk the issue counter, wait for the last pop.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= S_IDLE;
            r_n <= 6'd32;
            r_issue <= 6'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_state <= S_FETCH;
                        r_n <= w_n_start;
                        r_issue <= 6'd0;
                    end
                end
                S_FETCH: begin
                    if (w_issue) begin
                        r_issue <= r_issue + 6'd1;
                        if (w_last_issue) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_head_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // One-deep tag pipeline aligning sel/idx/last with the returning read data.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_inflight <= 1'b0;
            r_tag_sel <= 1'b0;
            r_tag_idx <= 5'd0;
            r_tag_last <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag_sel <= w_bank;
                r_tag_idx <= w_idx;
                r_tag_last <= w_last_issue;
            end
        end
    end

    // FIFO storage; contents need no reset because the count gates visibility.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= MEM_RDATA;
            r_mem_sel[r_wr_ptr] <= r_tag_sel;
            r_mem_idx[r_wr_ptr] <= r_tag_idx;
            r_mem_last[r_wr_ptr] <= r_tag_last;
        end
    end

    // FIFO pointers and occupancy; pointers wrap modulo the depth.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10: r_count <= r_count + CW'(1);
                2'b01: r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
